instruction_fetch_unit: RTL and testbench

//  Producer side of the instruction interface that feeds the decode-stage controller.
//  It owns the PC, issues word reads to a 1-cycle-latency synchronous instruction memory,
//  and buffers returned words in a small FIFO. Words are presented to ID over a

---
 rtl/instruction_fetch_unit_if.sv | 30 +++
 rtl/instruction_fetch_unit.sv | 108 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instruction_fetch_unit_if                                    |
// | Description : Memory, decode-handshake and redirect signals of the fetch   |
// |               unit, with master (fetch unit) and slave (memory/ID) views.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface instruction_fetch_unit_if;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_misalign;

    modport master (
        output imem_en, imem_addr, out_valid, out_instr, out_pc, fetch_misalign,
        input  imem_rdata, out_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_en, imem_addr, out_valid, out_instr, out_pc, fetch_misalign,
        output imem_rdata, out_ready, redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instruction_fetch_unit                                       |
// | Description : PC owner, 1-cycle imem reader and small instruction buffer   |
// |               feeding ID over valid/ready, with redirect/flush support.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    instruction_fetch_unit_if.master bus
);
    localparam int          PTR_W    = $clog2(FIFO_DEPTH);
    localparam int          CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int          OCC_W    = CNT_W + 1;
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             inflight_q, inflight_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      instr_buf_q [FIFO_DEPTH];
    logic [31:0]      instr_buf_d [FIFO_DEPTH];
    logic [31:0]      pc_buf_q    [FIFO_DEPTH];
    logic [31:0]      pc_buf_d    [FIFO_DEPTH];

    logic             pop;
    logic             push;
    logic             issue;
    logic [OCC_W-1:0] occupancy;

    always_comb begin
        pop       = (count_q != '0) & bus.out_ready;
        push      = inflight_q & ~bus.redirect_valid;
        // Buffered plus in-flight words after this cycle's pop must leave room.
        occupancy = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
        issue     = reset_n & ~bus.redirect_valid & (occupancy < OCC_W'(FIFO_DEPTH));

        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        inflight_d  = issue;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        instr_buf_d = instr_buf_q;
        pc_buf_d    = pc_buf_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        misalign_d  = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);

        if (issue) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
        end
        if (push) begin
            instr_buf_d[wr_ptr_q] = bus.imem_rdata;
            pc_buf_d[wr_ptr_q]    = req_pc_q;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (bus.redirect_valid) begin
            pc_d     = {bus.redirect_pc[31:2], 2'b00};
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC_ALIGNED;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_buf_q[i] <= '0;
                pc_buf_q[i]    <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            inflight_q  <= inflight_d;
            misalign_q  <= misalign_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            instr_buf_q <= instr_buf_d;
            pc_buf_q    <= pc_buf_d;
        end
    end

    assign bus.imem_en        = issue;
    assign bus.imem_addr      = pc_q;
    assign bus.out_valid      = (count_q != '0);
    assign bus.out_instr      = instr_buf_q[rd_ptr_q];
    assign bus.out_pc         = pc_buf_q[rd_ptr_q];
    assign bus.fetch_misalign = misalign_q;
endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instruction_fetch_unit                                    |
// | Description : Randomized bench for instruction_fetch_unit with a queue-    |
// |               based model of issued words and a behavioural memory.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_instruction_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_3000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h1000_0000 + ((a - 32'h0000_3000) >> 2);
    endfunction

    initial bus.imem_rdata = '0;
    always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= memf(bus.imem_addr);

    // Model: every issued word, oldest first, with the cycle it becomes visible.
    logic [31:0] q_pc [$];
    int          q_rdy[$];
    int          cyc = 0;
    logic [31:0] nxt = RPC;
    logic        mis_m = 1'b0;
    logic        e_valid, e_pop, e_en, e_mis;
    logic [31:0] e_addr, e_pc, e_instr;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic model_eval();
        @(negedge clk);
        e_valid = (q_pc.size() > 0) && (q_rdy[0] <= cyc);
        e_pop   = e_valid & bus.out_ready;
        e_en    = reset_n & ~bus.redirect_valid & ((q_pc.size() - int'(e_pop)) < DEPTH);
        e_addr  = nxt;
        e_pc    = e_valid ? q_pc[0] : 32'h0;
        e_instr = memf(e_pc);
        e_mis   = mis_m;
    endtask

    task automatic model_edge();
        @(posedge clk);
        if (!reset_n) begin
            q_pc.delete(); q_rdy.delete();
            nxt = RPC; mis_m = 1'b0;
        end else begin
            if (e_pop) begin
                void'(q_pc.pop_front()); void'(q_rdy.pop_front());
            end
            if (bus.redirect_valid) begin
                q_pc.delete(); q_rdy.delete();
                nxt   = {bus.redirect_pc[31:2], 2'b00};
                mis_m = |bus.redirect_pc[1:0];
            end else begin
                mis_m = 1'b0;
                if (e_en) begin
                    q_pc.push_back(nxt); q_rdy.push_back(cyc + 2);
                    nxt = nxt + 32'd4;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        repeat (2) model_edge();
        model_eval();
        n_chk++; if (bus.imem_en !== 1'b0) $display("FAIL reset_en got=%b exp=0", bus.imem_en); else n_pass++;
        n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.out_valid); else n_pass++;
        n_chk++; if (bus.out_instr !== 32'h0) $display("FAIL reset_instr got=%h exp=0", bus.out_instr); else n_pass++;
        n_chk++; if (bus.out_pc !== 32'h0) $display("FAIL reset_pc got=%h exp=0", bus.out_pc); else n_pass++;
        n_chk++; if (bus.fetch_misalign !== 1'b0) $display("FAIL reset_mis got=%b exp=0", bus.fetch_misalign); else n_pass++;
        model_edge();
        reset_n = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 68; i++) begin
            bus.out_ready = (i < 12) ? 1'b1 : (i < 18) ? 1'b0 : (i < 28) ? 1'b1 : 1'($urandom_range(0, 1));
            model_eval();
            if (i < 12) begin
                n_chk++;
                if (bus.imem_en !== 1'b1 || bus.imem_addr !== RPC + 32'(4 * i))
                    $display("FAIL stream_addr i=%0d got=%b/%h exp=1/%h", i, bus.imem_en, bus.imem_addr, RPC + 32'(4 * i));
                else n_pass++;
                n_chk++;
                if (bus.out_valid !== (i >= 2)) $display("FAIL stream_lat i=%0d got=%b exp=%b", i, bus.out_valid, i >= 2);
                else n_pass++;
            end
            n_chk++; if (bus.imem_en !== e_en) $display("FAIL stream_en cyc=%0d got=%b exp=%b", cyc, bus.imem_en, e_en); else n_pass++;
            if (e_en) begin
                n_chk++; if (bus.imem_addr !== e_addr) $display("FAIL stream_iaddr cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, e_addr); else n_pass++;
            end
            n_chk++; if (bus.out_valid !== e_valid) $display("FAIL stream_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, e_valid); else n_pass++;
            if (e_valid) begin
                n_chk++;
                if ({bus.out_pc, bus.out_instr} !== {e_pc, e_instr})
                    $display("FAIL stream_word cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.out_pc, bus.out_instr, e_pc, e_instr);
                else n_pass++;
            end
            model_edge();
        end
    endtask

    task automatic test_redirect();
        logic [31:0] t;
        for (int i = 0; i < 100; i++) begin
            bus.redirect_valid = 1'b0;
            bus.out_ready = (i < 5) ? 1'b0 : 1'b1;
            if (i == 4)  begin bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h3400; end
            if (i == 13) begin bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h3000; end
            if (i == 18) begin bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h3400; end
            if (i == 24) begin bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h3402; end
            if (i >= 27) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) begin
                    t = 32'h3000 + 32'($urandom_range(0, 63) << 2);
                    if ($urandom_range(0, 3) == 0) t = t + 32'($urandom_range(1, 3));
                    bus.redirect_valid = 1'b1; bus.redirect_pc = t;
                end
            end
            model_eval();
            if (i == 5) begin
                n_chk++;
                if (bus.imem_en !== 1'b1 || bus.imem_addr !== 32'h3400)
                    $display("FAIL redir_addr got=%b/%h exp=1/00003400", bus.imem_en, bus.imem_addr);
                else n_pass++;
            end
            if (i == 5 || i == 6) begin
                n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL redir_flush i=%0d got=%b exp=0", i, bus.out_valid); else n_pass++;
            end
            if (i == 7 || i == 21) begin
                n_chk++;
                if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h3400)
                    $display("FAIL redir_first i=%0d got=%b/%h exp=1/00003400", i, bus.out_valid, bus.out_pc);
                else n_pass++;
            end
            if (i == 18) begin
                n_chk++;
                if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h3008)
                    $display("FAIL redir_pop got=%b/%h exp=1/00003008", bus.out_valid, bus.out_pc);
                else n_pass++;
            end
            if (i == 25) begin
                n_chk++;
                if (bus.fetch_misalign !== 1'b1 || bus.imem_en !== 1'b1 || bus.imem_addr !== 32'h3400)
                    $display("FAIL misalign got=%b/%b/%h exp=1/1/00003400", bus.fetch_misalign, bus.imem_en, bus.imem_addr);
                else n_pass++;
            end
            n_chk++; if (bus.imem_en !== e_en) $display("FAIL redir_en cyc=%0d got=%b exp=%b", cyc, bus.imem_en, e_en); else n_pass++;
            if (e_en) begin
                n_chk++; if (bus.imem_addr !== e_addr) $display("FAIL redir_iaddr cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, e_addr); else n_pass++;
            end
            n_chk++; if (bus.out_valid !== e_valid) $display("FAIL redir_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, e_valid); else n_pass++;
            if (e_valid) begin
                n_chk++;
                if ({bus.out_pc, bus.out_instr} !== {e_pc, e_instr})
                    $display("FAIL redir_word cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.out_pc, bus.out_instr, e_pc, e_instr);
                else n_pass++;
            end
            n_chk++; if (bus.fetch_misalign !== e_mis) $display("FAIL redir_mis cyc=%0d got=%b exp=%b", cyc, bus.fetch_misalign, e_mis); else n_pass++;
            model_edge();
        end
        bus.redirect_valid = 1'b0;
    endtask

    task automatic test_wrap_reset();
        for (int i = 0; i < 16; i++) begin
            bus.out_ready = 1'b1;
            bus.redirect_valid = (i == 0);
            bus.redirect_pc = 32'hFFFF_FFF0;
            reset_n = (i != 7);
            model_eval();
            if (i == 4 || i == 5) begin
                n_chk++;
                if (bus.imem_en !== 1'b1 || bus.imem_addr !== ((i == 4) ? 32'hFFFF_FFFC : 32'h0))
                    $display("FAIL wrap_addr i=%0d got=%b/%h", i, bus.imem_en, bus.imem_addr);
                else n_pass++;
            end
            if (i == 8) begin
                n_chk++;
                if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.imem_en !== 1'b1 || bus.imem_addr !== RPC)
                    $display("FAIL wrap_reset got=%b/%h/%b/%h exp=0/0/1/%h", bus.out_valid, bus.out_pc, bus.imem_en, bus.imem_addr, RPC);
                else n_pass++;
            end
            if (i == 10) begin
                n_chk++;
                if (bus.out_valid !== 1'b1 || bus.out_pc !== RPC)
                    $display("FAIL wrap_refetch got=%b/%h exp=1/%h", bus.out_valid, bus.out_pc, RPC);
                else n_pass++;
            end
            n_chk++; if (bus.imem_en !== e_en) $display("FAIL wrap_en cyc=%0d got=%b exp=%b", cyc, bus.imem_en, e_en); else n_pass++;
            if (e_en) begin
                n_chk++; if (bus.imem_addr !== e_addr) $display("FAIL wrap_iaddr cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, e_addr); else n_pass++;
            end
            n_chk++; if (bus.out_valid !== e_valid) $display("FAIL wrap_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, e_valid); else n_pass++;
            if (e_valid) begin
                n_chk++;
                if ({bus.out_pc, bus.out_instr} !== {e_pc, e_instr})
                    $display("FAIL wrap_word cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.out_pc, bus.out_instr, e_pc, e_instr);
                else n_pass++;
            end
            model_edge();
        end
        reset_n = 1'b1;
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_redirect();
        test_wrap_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
